// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake
// and drives the IF/ID payload, with stall holding and branch/jump redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        Stall,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] PCResult,
    output logic        IMemReq,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    output logic        MisalignedFault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] hold_data_r;

    assign IMemReq = (state_r == FETCH);

    // Fetch sequencer: PC, IF/ID payload, hold buffer and fault flag.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r         <= BOOT;
            PCResult        <= RESET_PC;
            Instruction     <= 32'h00000000;
            InstrPC         <= 32'h00000000;
            InstrValid      <= 1'b0;
            MisalignedFault <= 1'b0;
            hold_data_r     <= 32'h00000000;
        end else if (RedirectValid && (state_r != FAULT)) begin
            // A redirect wins over stalls and drops any same-edge ack data.
            PCResult    <= RedirectTarget;
            InstrValid  <= 1'b0;
            hold_data_r <= 32'h00000000;
            if (RedirectTarget[1:0] == 2'b00) begin
                state_r <= FETCH;
            end else begin
                MisalignedFault <= 1'b1;
                state_r         <= FAULT;
            end
        end else begin
            case (state_r)
                BOOT: begin
                    state_r <= FETCH;
                end
                FETCH: begin
                    if (IMemAck) begin
                        if (!Stall) begin
                            Instruction <= IMemData;
                            InstrPC     <= PCResult;
                            InstrValid  <= 1'b1;
                            PCResult    <= PCAddResult;
                        end else begin
                            hold_data_r <= IMemData;
                            state_r     <= HOLD;
                        end
                    end else if (!Stall) begin
                        InstrValid <= 1'b0;
                    end else begin
                        InstrValid <= InstrValid;
                    end
                end
                HOLD: begin
                    // The held word belongs to the PC that was frozen at capture.
                    if (!Stall) begin
                        Instruction <= hold_data_r;
                        InstrPC     <= PCResult;
                        InstrValid  <= 1'b1;
                        PCResult    <= PCAddResult;
                        state_r     <= FETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                FAULT: begin
                    InstrValid <= 1'b0;
                    state_r    <= FAULT;
                end
                default: begin
                    InstrValid <= 1'b0;
                    state_r    <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// stimulus, all compared against a transaction-level reference model.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCAddResult;
    logic        Stall;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] PCResult;
    logic        IMemReq;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        MisalignedFault;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural PC, delivered payload, pending held words.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_iv;
    logic        m_fault;
    logic        m_boot;
    logic [31:0] m_held[$];

    always #5 Clk = ~Clk;

    assign PCAddResult = PCResult + 32'd4;

    instruction_fetch_unit #(.RESET_PC(32'h00000000)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PCAddResult    (PCAddResult),
        .Stall          (Stall),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .IMemAck        (IMemAck),
        .IMemData       (IMemData),
        .PCResult       (PCResult),
        .IMemReq        (IMemReq),
        .Instruction    (Instruction),
        .InstrPC        (InstrPC),
        .InstrValid     (InstrValid),
        .MisalignedFault(MisalignedFault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h20080001 + (a >> 2) * 32'h00010001;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_step(input logic rst, input logic st, input logic rv,
                              input logic [31:0] rt, input logic ack, input logic [31:0] data);
        if (!rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_iv = 1'b0;
            m_fault = 1'b0; m_boot = 1'b1; m_held.delete();
        end else if (m_fault) begin
            m_iv = 1'b0;
        end else if (rv) begin
            m_pc = rt; m_iv = 1'b0; m_boot = 1'b0; m_held.delete();
            if (rt[1:0] != 2'b00) m_fault = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_held.size() > 0) begin
            if (!st) begin
                m_instr = m_held.pop_front(); m_ipc = m_pc; m_iv = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else if (ack) begin
            if (!st) begin
                m_instr = data; m_ipc = m_pc; m_iv = 1'b1; m_pc = m_pc + 32'd4;
            end else begin
                m_held.push_back(data);
            end
        end else if (!st) begin
            m_iv = 1'b0;
        end
    endtask

    task automatic check_all();
        logic exp_req;
        exp_req = !m_boot && !m_fault && (m_held.size() == 0);
        check_value("pc", PCResult, m_pc);
        check_value("req", {31'b0, IMemReq}, {31'b0, exp_req});
        check_value("valid", {31'b0, InstrValid}, {31'b0, m_iv});
        check_value("fault", {31'b0, MisalignedFault}, {31'b0, m_fault});
        check_value("instr", Instruction, m_instr);
        check_value("instr_pc", InstrPC, m_ipc);
    endtask

    task automatic cycle(input logic rst, input logic st, input logic rv,
                         input logic [31:0] rt, input logic ack, input logic [31:0] data);
        Reset = rst; Stall = st; RedirectValid = rv; RedirectTarget = rt;
        IMemAck = ack; IMemData = data;
        model_step(rst, st, rv, rt, ack, data);
        @(posedge Clk);
        @(negedge Clk);
        check_all();
    endtask

    task automatic step(input logic rst, input logic st, input logic rv,
                        input logic [31:0] rt, input logic ack);
        cycle(rst, st, rv, rt, ack, mem_word(m_pc));
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] tgt;
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
        m_iv = 1'b0; m_fault = 1'b0; m_boot = 1'b1;

        // Reset, one BOOT cycle, then zero-wait memory.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_value("rst_pc", PCResult, 32'h0);
        check_value("rst_req", {31'b0, IMemReq}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_value("first_req", {31'b0, IMemReq}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            check_value("zw_ipc", InstrPC, 32'(i * 4));
            check_value("zw_instr", Instruction, 32'h20080001 + 32'(i) * 32'h00010001);
        end

        // Three-cycle ack latency at PC 0x10.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            check_value("lat_pc", PCResult, 32'h10);
            check_value("lat_valid", {31'b0, InstrValid}, 32'h0);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check_value("lat_ipc", InstrPC, 32'h10);

        // Stall on the ack edge at PC 0x20, held for four cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hAC0A0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            check_value("hold_req", {31'b0, IMemReq}, 32'h0);
            check_value("hold_ipc", InstrPC, 32'h1C);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_value("rel_instr", Instruction, 32'hAC0A0000);
        check_value("rel_ipc", InstrPC, 32'h20);
        check_value("rel_pc", PCResult, 32'h24);

        // Redirect to 0x400 on the same edge as an ack at PC 0x8.
        step(1'b1, 1'b0, 1'b1, 32'h8, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h400, 1'b1);
        check_value("rd_valid", {31'b0, InstrValid}, 32'h0);
        check_value("rd_pc", PCResult, 32'h400);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check_value("rd_ipc", InstrPC, 32'h400);

        // Misaligned redirect: sticky fault until reset.
        step(1'b1, 1'b0, 1'b1, 32'h402, 1'b0);
        check_value("mis_fault", {31'b0, MisalignedFault}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h500, 1'b1);
            check_value("mis_pc", PCResult, 32'h402);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_value("mis_clr", {31'b0, MisalignedFault}, 32'h0);
        check_value("mis_rstpc", PCResult, 32'h0);

        // Wrap-around from the top of the address space.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check_value("wrap_ipc0", InstrPC, 32'hFFFFFFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check_value("wrap_ipc1", InstrPC, 32'h0);
        check_value("wrap_fault", {31'b0, MisalignedFault}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom();
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFFFFF8;
            else tgt = {r[31:2], 2'b00};
            if ($urandom_range(0, 31) == 0) tgt[1:0] = r[1:0];
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, tgt, $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
